// File: rtl/b200_dbg_uart_pkg.sv
// Shared state encoding and frame constants for the b200 debug UART transmitter.
// Build option DEBUG_UART_PARITY_EN adds an even-parity bit between data and stop.
package b200_dbg_uart_pkg;

  localparam int unsigned UART_CLKDIV_DEFAULT = 868;
  localparam int unsigned UART_DATA_BITS      = 8;

`ifdef DEBUG_UART_PARITY_EN
  localparam int unsigned UART_FRAME_BITS = 11;
`else
  localparam int unsigned UART_FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef DEBUG_UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/b200_dbg_uart_fifo.sv
// Synchronous FIFO for the debug UART: registered occupancy count, full/empty
// decided by the extra pointer MSB, pushes when full and pops when empty are ignored.
module b200_dbg_uart_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          bus_clk,
  input  logic          reset_global,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   level_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];
  assign level     = level_r;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge bus_clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + PTR_ONE;
        2'b01:   level_r <= level_r - PTR_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/b200_dbg_uart_tx.sv
// Debug UART transmitter (8N1, or 8E1 with DEBUG_UART_PARITY_EN) fed by a byte FIFO.
// txd is registered from the next-state decode so it changes on the same edge as the state.
module b200_dbg_uart_tx
  import b200_dbg_uart_pkg::*;
#(
  parameter int unsigned CLKDIV  = UART_CLKDIV_DEFAULT,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic             bus_clk,
  input  logic             reset_global,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             txd,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKDIV - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e      state_r;
  uart_state_e      state_s;
  logic [15:0]      baud_r;
  logic [15:0]      baud_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_s;
  logic             txd_r;
  logic             txd_s;
  logic             pop_s;
  logic             baud_done_s;
  logic [7:0]       fifo_rd_data_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [FIFO_AW:0] fifo_level_s;
`ifdef DEBUG_UART_PARITY_EN
  logic             parity_r;
  logic             parity_s;
`endif

  b200_dbg_uart_fifo #(
    .AW (FIFO_AW),
    .DW (8)
  ) u_fifo (
    .bus_clk      (bus_clk),
    .reset_global (reset_global),
    .push         (s_tvalid),
    .wr_data      (s_tdata),
    .pop          (pop_s),
    .rd_data      (fifo_rd_data_s),
    .full         (fifo_full_s),
    .empty        (fifo_empty_s),
    .level        (fifo_level_s)
  );

  assign s_tready    = !fifo_full_s;
  assign fifo_level  = fifo_level_s;
  assign busy        = (state_r != ST_IDLE) || (fifo_level_s != {(FIFO_AW+1){1'b0}});
  assign txd         = txd_r;
  assign baud_done_s = (baud_r == BAUD_LAST);

  // Next-state, baud timing, shift register and registered-txd decode.
  always_comb begin
    state_s   = state_r;
    baud_s    = baud_r + 16'd1;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    pop_s     = 1'b0;
`ifdef DEBUG_UART_PARITY_EN
    parity_s  = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        baud_s = 16'd0;
        if (!fifo_empty_s) begin
          pop_s    = 1'b1;
          shift_s  = fifo_rd_data_s;
`ifdef DEBUG_UART_PARITY_EN
          parity_s = even_parity(fifo_rd_data_s);
`endif
          state_s  = ST_START;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_done_s) begin
          baud_s    = 16'd0;
          bit_idx_s = 3'd0;
          state_s   = ST_DATA;
        end else begin
          state_s   = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_done_s) begin
          baud_s = 16'd0;
          if (bit_idx_r == BIT_LAST) begin
`ifdef DEBUG_UART_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            shift_s   = {1'b0, shift_r[7:1]};
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef DEBUG_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_done_s) begin
          baud_s  = 16'd0;
          state_s = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done_s) begin
          baud_s = 16'd0;
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (!fifo_empty_s) begin
            pop_s    = 1'b1;
            shift_s  = fifo_rd_data_s;
`ifdef DEBUG_UART_PARITY_EN
            parity_s = even_parity(fifo_rd_data_s);
`endif
            state_s  = ST_START;
          end else begin
            state_s  = ST_IDLE;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        baud_s  = 16'd0;
        state_s = ST_IDLE;
      end
    endcase

    case (state_s)
      ST_IDLE:   txd_s = 1'b1;
      ST_START:  txd_s = 1'b0;
      ST_DATA:   txd_s = shift_s[0];
`ifdef DEBUG_UART_PARITY_EN
      ST_PARITY: txd_s = parity_s;
`endif
      ST_STOP:   txd_s = 1'b1;
      default:   txd_s = 1'b1;
    endcase
  end

  // FSM and datapath registers; reset abandons any frame and idles the line high.
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      state_r   <= ST_IDLE;
      baud_r    <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      txd_r     <= 1'b1;
`ifdef DEBUG_UART_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      txd_r     <= txd_s;
`ifdef DEBUG_UART_PARITY_EN
      parity_r  <= parity_s;
`endif
    end
  end

endmodule

// File: tb/tb_b200_dbg_uart_tx.sv
// Self-checking bench for b200_dbg_uart_tx: a line decoder recovers frames from txd and
// compares them with a byte scoreboard; instance dut_a runs CLKDIV=4, dut_b CLKDIV=2.
module tb_b200_dbg_uart_tx;

  localparam int DIV_A = 4;
  localparam int DIV_B = 2;
  localparam int DEPTH = 16;
`ifdef DEBUG_UART_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  logic       bus_clk = 1'b0;
  logic       reset_global;
  logic [7:0] a_tdata, b_tdata;
  logic       a_tvalid, b_tvalid;
  logic       a_tready, b_tready;
  logic       a_txd, b_txd;
  logic       a_busy, b_busy;
  logic [4:0] a_level, b_level;
  logic       mon_sel;
  logic       mon_txd;
  int         cyc = 0;
  int         n_chk;
  int         n_fail;
  logic [7:0] sbq[$];

  always #5 bus_clk = ~bus_clk;
  always @(posedge bus_clk) cyc <= cyc + 1;
  assign mon_txd = mon_sel ? b_txd : a_txd;

  b200_dbg_uart_tx #(.CLKDIV(DIV_A), .FIFO_AW(4)) dut_a (
    .bus_clk(bus_clk), .reset_global(reset_global), .s_tdata(a_tdata), .s_tvalid(a_tvalid),
    .s_tready(a_tready), .txd(a_txd), .busy(a_busy), .fifo_level(a_level));

  b200_dbg_uart_tx #(.CLKDIV(DIV_B), .FIFO_AW(4)) dut_b (
    .bus_clk(bus_clk), .reset_global(reset_global), .s_tdata(b_tdata), .s_tvalid(b_tvalid),
    .s_tready(b_tready), .txd(b_txd), .busy(b_busy), .fifo_level(b_level));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic [7:0] d, input logic v);
    if (sel) begin b_tdata = d; b_tvalid = v; end
    else begin a_tdata = d; a_tvalid = v; end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b_tready : a_tready;
  endfunction

  // Single push; pc is the cycle count just after the accepting edge.
  task automatic push1(input bit sel, input logic [7:0] d, output int pc);
    int g;
    g = 0;
    set_in(sel, d, 1'b1);
    while (!rdy(sel) && g < 5000) begin @(negedge bus_clk); g++; end
    sbq.push_back(d);
    @(negedge bus_clk);
    set_in(sel, 8'h00, 1'b0);
    pc = cyc;
  endtask

  // Hold valid until n bytes accepted; counts acceptances before the first not-ready.
  task automatic burst(input bit sel, input int n, input int mode, input logic [7:0] base,
                       output int acc_low);
    int acc, g;
    bit low_seen;
    logic [7:0] d;
    acc = 0; g = 0; low_seen = 1'b0; acc_low = 0;
    while (acc < n && g < 5000) begin
      d = (mode == 1) ? (((acc % 2) == 0) ? 8'hFF : 8'h00) : base + 8'(acc);
      set_in(sel, d, 1'b1);
      if (rdy(sel)) begin
        sbq.push_back(d);
        acc++;
        if (!low_seen) acc_low++;
      end else begin
        low_seen = 1'b1;
      end
      @(negedge bus_clk);
      g++;
    end
    set_in(sel, 8'h00, 1'b0);
  endtask

  // Decode one frame: every bit must hold for exactly div samples.
  task automatic rx_frame(input int div, output logic [7:0] d, output int sc, output bit got);
    int w, bad;
    logic v, stop_v;
`ifdef DEBUG_UART_PARITY_EN
    logic par_v;
    par_v = 1'b0;
`endif
    got = 1'b0; d = 8'h00; sc = 0; w = 0; bad = 0; v = 1'b0; stop_v = 1'b0;
    do begin @(negedge bus_clk); w++; end while (mon_txd !== 1'b0 && w < 3000);
    if (mon_txd !== 1'b0) return;
    got = 1'b1;
    sc = cyc;
    for (int s = 0; s < NSLOT; s++) begin
      for (int k = 0; k < div; k++) begin
        if (s != 0 || k != 0) @(negedge bus_clk);
        if (k == 0) v = mon_txd;
        else if (mon_txd !== v) bad++;
      end
      if (s >= 1 && s <= 8) d = {v, d[7:1]};
      else if (s == NSLOT - 1) stop_v = v;
`ifdef DEBUG_UART_PARITY_EN
      else if (s == 9) par_v = v;
`endif
    end
    chk("bit_width", 32'(bad), 32'd0);
    chk("stop_bit", 32'(stop_v), 32'd1);
`ifdef DEBUG_UART_PARITY_EN
    chk("parity_bit", 32'(par_v), 32'(^d));
`endif
  endtask

  task automatic rx_n(input int n, input int div, input bit exact, output int first_sc);
    logic [7:0] d, e;
    int sc, prev;
    bit got;
    prev = -1; first_sc = 0;
    for (int i = 0; i < n; i++) begin
      rx_frame(div, d, sc, got);
      chk("rx_frame_seen", 32'(got), 32'd1);
      if (!got) break;
      if (i == 0) first_sc = sc;
      chk("sb_has_byte", 32'(sbq.size() > 0), 32'd1);
      e = (sbq.size() > 0) ? sbq.pop_front() : ~d;
      chk("rx_data", 32'(d), 32'(e));
      if (prev >= 0) begin
        if (exact) chk("frame_spacing", 32'(sc - prev), 32'(NSLOT * div));
        else chk("frame_gap_min", 32'(sc - prev >= NSLOT * div), 32'd1);
      end
      prev = sc;
    end
  endtask

  initial begin
    int pc, p0, sc0, acc_low, g, lows, busys;
    n_chk = 0; n_fail = 0; mon_sel = 1'b0;
    a_tdata = 8'h00; a_tvalid = 1'b0; b_tdata = 8'h00; b_tvalid = 1'b0;
    reset_global = 1'b1;
    repeat (3) @(negedge bus_clk);
    chk("rst_txd_a", 32'(a_txd), 32'd1);
    chk("rst_busy_a", 32'(a_busy), 32'd0);
    chk("rst_ready_a", 32'(a_tready), 32'd1);
    chk("rst_level_a", 32'(a_level), 32'd0);
    chk("rst_txd_b", 32'(b_txd), 32'd1);
    chk("rst_busy_b", 32'(b_busy), 32'd0);
    chk("rst_level_b", 32'(b_level), 32'd0);
    reset_global = 1'b0;
    @(negedge bus_clk);

    // Single 0x55 frame, start bit on the cycle after acceptance.
    push1(1'b0, 8'h55, pc);
    rx_n(1, DIV_A, 1'b1, sc0);
    chk("start_latency", 32'(sc0 - pc), 32'd1);
    chk("busy_in_stop", 32'(a_busy), 32'd1);
    @(negedge bus_clk);
    chk("busy_after_frame", 32'(a_busy), 32'd0);
    chk("txd_idle", 32'(a_txd), 32'd1);

    // Held-valid burst of 20 incrementing bytes.
    fork
      burst(1'b0, 20, 0, 8'h10, acc_low);
      rx_n(20, DIV_A, 1'b1, sc0);
    join
    chk("accepted_before_full", 32'(acc_low), 32'(DEPTH + 1));
    @(negedge bus_clk);
    chk("burst_busy_end", 32'(a_busy), 32'd0);

    // Push coinciding with the pop at end of stop while 5 bytes are queued.
    fork
      rx_n(7, DIV_A, 1'b1, sc0);
      begin
        push1(1'b0, 8'($urandom), p0);
        for (int i = 0; i < 5; i++) push1(1'b0, 8'($urandom), pc);
        g = 0;
        while (cyc != p0 + 40 && g < 500) begin @(negedge bus_clk); g++; end
        chk("level_before_pushpop", 32'(a_level), 32'd5);
        set_in(1'b0, 8'hA7, 1'b1);
        sbq.push_back(8'hA7);
        @(negedge bus_clk);
        set_in(1'b0, 8'h00, 1'b0);
        chk("level_after_pushpop", 32'(a_level), 32'd5);
      end
    join
    @(negedge bus_clk);
    chk("pushpop_level_end", 32'(a_level), 32'd0);

    // Random bytes with random idle gaps.
    fork
      rx_n(12, DIV_A, 1'b0, sc0);
      for (int i = 0; i < 12; i++) begin
        push1(1'b0, 8'($urandom), pc);
        repeat ($urandom_range(0, 60)) @(negedge bus_clk);
      end
    join

    // Parity-relevant patterns (0x07 odd weight, 0x03 even weight).
    push1(1'b0, 8'h07, pc);
    rx_n(1, DIV_A, 1'b1, sc0);
    push1(1'b0, 8'h03, pc);
    rx_n(1, DIV_A, 1'b1, sc0);
    @(negedge bus_clk);

    // Reset during data bit 3 with 6 bytes queued.
    push1(1'b0, 8'($urandom), p0);
    for (int i = 0; i < 6; i++) push1(1'b0, 8'($urandom), pc);
    g = 0;
    while (cyc != p0 + 18 && g < 500) begin @(negedge bus_clk); g++; end
    chk("level_before_reset", 32'(a_level), 32'd6);
    reset_global = 1'b1;
    #1;
    chk("reset_txd_now", 32'(a_txd), 32'd1);
    chk("reset_busy_now", 32'(a_busy), 32'd0);
    chk("reset_level_now", 32'(a_level), 32'd0);
    chk("reset_ready_now", 32'(a_tready), 32'd1);
    @(negedge bus_clk);
    @(negedge bus_clk);
    reset_global = 1'b0;
    sbq.delete();
    lows = 0; busys = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge bus_clk);
      if (a_txd !== 1'b1) lows++;
      if (a_busy !== 1'b0) busys++;
    end
    chk("post_reset_no_start", 32'(lows), 32'd0);
    chk("post_reset_busy", 32'(busys), 32'd0);
    chk("post_reset_level", 32'(a_level), 32'd0);

    // CLKDIV=2 alternating 0xFF/0x00 burst.
    mon_sel = 1'b1;
    fork
      burst(1'b1, 10, 1, 8'h00, acc_low);
      rx_n(10, DIV_B, 1'b1, sc0);
    join
    @(negedge bus_clk);
    chk("div2_busy_end", 32'(b_busy), 32'd0);
    chk("div2_sb_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/b200_dbg_uart_tx.md
B200_DBG_UART_TX -- requirements
Module: b200_dbg_uart_tx

Interface
REQ-001 SHALL have parameter CLKDIV, default 868, meaning bus_clk cycles per UART bit (868 gives 115200 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_AW, default 4, meaning log2 of FIFO depth (16 entries).
REQ-003 SHALL have port bus_clk  input  1  bus clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port reset_global  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port s_tdata  input  8  byte to transmit.
REQ-006 SHALL have port s_tvalid  input  1  s_tdata valid.
REQ-007 SHALL have port s_tready  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port txd  output  1  serial line; drives the FPGA_TXD0 pin.
REQ-009 SHALL have port busy  output  1  FIFO non-empty or frame in progress.
REQ-010 SHALL have port fifo_level  output  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.

Function
REQ-011 SHALL push s_tdata into the FIFO on every cycle where s_tvalid and s_tready are both high.
REQ-012 SHALL drive s_tready as !full, combinationally from FIFO state; bytes are never dropped.
REQ-013 SHALL run the FSM states IDLE, START, DATA, STOP; the PARITY state exists only per REQ-026.
REQ-014 In IDLE with the FIFO non-empty, SHALL pop one byte into the shift register and enter START on the next cycle.
REQ-015 SHALL hold each state for exactly CLKDIV cycles, timed by a baud counter that runs 0..CLKDIV-1 and restarts on every state entry.
REQ-016 SHALL drive txd low in START.
REQ-017 SHALL drive txd with data bits LSB first in DATA, using a 3-bit index that leaves DATA after bit 7.
REQ-018 SHALL drive txd high in STOP and in IDLE.
REQ-019 SHALL register txd; there is no combinational path from any input to txd.
REQ-020 At the end of STOP, SHALL pop the next byte and enter START directly if the FIFO is non-empty (no idle gap; frame period exactly 10*CLKDIV), else enter IDLE.
REQ-021 SHALL allow a simultaneous push and pop: fifo_level is unchanged and ordering is preserved.
REQ-022 SHALL wrap the FIFO read and write pointers modulo 2^FIFO_AW, with full/empty decided by an extra pointer MSB.
REQ-023 SHALL assert busy whenever state != IDLE or fifo_level != 0.

Reset
REQ-024 While reset_global is high, SHALL hold txd=1, state=IDLE, pointers and fifo_level=0, baud counter=0, busy=0 and s_tready=1 (FIFO empty).
REQ-025 Reset asserted mid-frame SHALL abandon the frame, force txd high immediately, and discard FIFO contents; there is no partial retransmission after release.

Configuration
REQ-026 With DEBUG_UART_PARITY_EN defined, SHALL insert a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the 8 data bits) for CLKDIV cycles, giving an 11*CLKDIV frame.
REQ-027 With DEBUG_UART_PARITY_EN undefined, SHALL generate no PARITY state or logic, giving an 8N1 frame of 10*CLKDIV cycles.

Structure
REQ-028 SHALL take the FSM state encoding, the default CLKDIV constant and the frame-length constants from shared package b200_dbg_uart_pkg.
REQ-029 SHALL implement the FIFO as sub-module b200_dbg_uart_fifo (synchronous, registered count, exposes full/empty/level).

Verification
REQ-030 CLKDIV=4, push 0x55 once -> txd low cycles 0-3 after START, then 1,0,1,0,1,0,1,0 for 4 cycles each, high 4 cycles, then IDLE and busy=0.
REQ-031 CLKDIV=4, s_tvalid held with 20 incrementing bytes -> exactly 17 accepted before the first s_tready low; all sent in order with 40-cycle frame spacing and no gaps.
REQ-032 Push and pop in the same cycle with fifo_level=5 -> fifo_level remains 5; output sequence matches input order.
REQ-033 reset_global pulsed during DATA bit 3 with 6 bytes queued -> txd=1 the same cycle; after release fifo_level=0, busy=0 and no further start bits.
REQ-034 DEBUG_UART_PARITY_EN defined, push 0x07 -> parity bit 1 after bit 7, frame length 44 cycles at CLKDIV=4; push 0x03 -> parity bit 0.
REQ-035 CLKDIV=2 with a 0xFF/0x00 alternating burst -> every bit exactly 2 cycles wide and no lost or duplicated bytes.
